// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 2-entry {instr, pc} queue in front of a single-outstanding IMEM port.
// Optional macro IFU_BYPASS_EN adds a same-cycle imem_rdata -> instr path when the queue is empty.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc [2];
  logic [1:0]  count, count_nxt;
  logic        head_valid, byp, consume, redirect, pop, ack_ok, wr, widx;
  logic [31:0] target;

  assign target     = branch_target & ~32'h3;
  assign head_valid = (count != 2'd0);

`ifdef IFU_BYPASS_EN
  assign byp    = (state == REQ) && imem_ack && !head_valid;
  assign instr  = byp ? imem_rdata : q_instr[0];
  assign pc_out = byp ? fetch_pc : q_pc[0];
`else
  assign byp    = 1'b0;
  assign instr  = q_instr[0];
  assign pc_out = q_pc[0];
`endif

  assign instr_valid = head_valid | byp;
  assign consume     = instr_valid & ~stall;
  assign redirect    = consume & pcsrc;
  assign pop         = head_valid & consume;
  // An ack is kept unless a redirect flushes the stream in the same cycle.
  assign ack_ok      = (state == REQ) && imem_ack && !redirect;
  // A bypassed word that is consumed immediately never needs a queue slot.
  assign wr          = ack_ok && !(byp && consume);
  assign widx        = (count == 2'd1) && !pop;
  assign count_nxt   = redirect ? 2'd0 : count + {1'b0, wr} - {1'b0, pop};

  assign imem_req  = (state != IDLE);
  assign imem_addr = fetch_pc;
  assign pc_plus8  = pc_out + 32'd8;
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];

  // A new request is only launched when a slot is guaranteed free on return.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count_nxt != 2'd2) state_nxt = REQ;
      REQ: begin
        if (imem_ack)      state_nxt = (count_nxt == 2'd2) ? IDLE : REQ;
        else if (redirect) state_nxt = DROP;
      end
      DROP: if (imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 2'd0;
      fetch_pc   <= RESET_VECTOR;
      redir_pc   <= RESET_VECTOR;
      q_instr[0] <= 32'd0;
      q_instr[1] <= 32'd0;
      q_pc[0]    <= 32'd0;
      q_pc[1]    <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // While a request is in flight, fetch_pc must keep driving imem_addr; park the target.
      if (redirect) begin
        if (state == REQ && !imem_ack) redir_pc <= target;
        else                           fetch_pc <= target;
      end else if (ack_ok) begin
        fetch_pc <= fetch_pc + 32'd4;
      end else if (state == DROP && imem_ack) begin
        fetch_pc <= redir_pc;
      end
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (wr) begin
        q_instr[widx] <= imem_rdata;
        q_pc[widx]    <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: decode vector table, directed corner sequences, random stream vs PC-sequence model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, stall, pcsrc, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out, pc_plus8;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  c;
    logic [1:0]  o;
    logic [5:0]  f;
    logic [3:0]  r;
  } vec_t;
  vec_t tab [4];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .pc_plus8(pc_plus8), .cond(cond), .op(op), .funct(funct), .rd(rd)
  );

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic [31:0] t, input logic a);
    stall         = s;
    pcsrc         = p;
    branch_target = t;
    imem_ack      = a & imem_req;
    imem_rdata    = memf(imem_addr);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic chk_tab(input int i);
    chk("tab_valid", {31'd0, instr_valid}, 32'd1);
    chk("tab_pc", pc_out, 32'(4 * i));
    chk("tab_pc8", pc_plus8, 32'(4 * i + 8));
    chk("tab_instr", instr, tab[i].data);
    chk("tab_cond", {28'd0, cond}, {28'd0, tab[i].c});
    chk("tab_op", {30'd0, op}, {30'd0, tab[i].o});
    chk("tab_funct", {26'd0, funct}, {26'd0, tab[i].f});
    chk("tab_rd", {28'd0, rd}, {28'd0, tab[i].r});
  endtask

  initial begin
    logic [31:0] exp_pc, prev_addr, w;
    logic        prev_req, prev_ack;
    int          consumed;

    tab[0] = '{32'hE3A0_1005, 4'hE, 2'b00, 6'b111010, 4'h1};
    tab[1] = '{32'h5A5F_C123, 4'h5, 2'b10, 6'h25,     4'hC};
    tab[2] = '{32'h0C3F_7000, 4'h0, 2'b11, 6'h03,     4'h7};
    tab[3] = '{32'hFFFF_FFFF, 4'hF, 2'b11, 6'h3F,     4'hF};

    // Reset state and first request
    do_reset;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_instr", instr, 32'd0);
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RV);

    // Decode table: sequential fetch from 0, stall low
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      imem_rdata = tab[i].data;
      #1;
      chk("tab_addr", imem_addr, 32'(4 * i));
      if (BYP) chk_tab(i);
      else chk("lat_novalid", {31'd0, instr_valid}, 32'd0);
      step;
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      if (!BYP) chk_tab(i);
      step;
    end

    // Stall fills the queue, fetch stops, release drains in order
    do_reset;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      step;
    end
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    chk("stall_head", pc_out, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drain_pc0", pc_out, 32'd0);
    chk("drain_i0", instr, memf(32'd0));
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drain_pc4", pc_out, 32'd4);
    chk("drain_i4", instr, memf(32'd4));
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'd8);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    chk("resume_pc8", pc_out, 32'd8);

    // Redirect while a request is outstanding
    do_reset;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    step;
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    chk("br_addr_out", imem_addr, 32'd4);
    chk("br_head", pc_out, 32'd0);
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'd4);
    chk("drop_novalid", {31'd0, instr_valid}, 32'd0);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("br_new_addr", imem_addr, 32'h100);
    if (!BYP) chk("br_novalid", {31'd0, instr_valid}, 32'd0);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    chk("br_valid", {31'd0, instr_valid}, 32'd1);
    chk("br_pc", pc_out, 32'h100);
    chk("br_instr", instr, memf(32'h100));

    // Reset asserted mid-request with an ack arriving during reset
    do_reset;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mid_novalid", {31'd0, instr_valid}, 32'd0);
    chk("mid_noreq", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("mid_req2", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, RV);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    chk("mid_pc", pc_out, RV);

    // Address wrap after branching to the top word
    do_reset;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    step;
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("wrap_head", pc_out, 32'd0);
    step;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    if (BYP) begin
      chk("byp_valid", {31'd0, instr_valid}, 32'd1);
      chk("byp_pc", pc_out, 32'hFFFF_FFFC);
      chk("byp_pc8", pc_plus8, 32'd4);
      chk("byp_instr", instr, memf(32'hFFFF_FFFC));
    end
    step;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    chk("wrap_zero_addr", imem_addr, 32'd0);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    if (!BYP) begin
      chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
      chk("wrap_pc8", pc_plus8, 32'd4);
      chk("wrap_instr", instr, memf(32'hFFFF_FFFC));
    end

    // Random traffic against a model of the expected PC stream
    do_reset;
    exp_pc    = RV;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    consumed  = 0;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 10) < 3, ($urandom % 8) == 0, $urandom, ($urandom % 3) != 0);
      if (prev_req && !prev_ack) begin
        chk("rnd_req_hold", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_hold", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (instr_valid) begin
        w = memf(exp_pc);
        chk("rnd_pc", pc_out, exp_pc);
        chk("rnd_instr", instr, w);
        chk("rnd_pc8", pc_plus8, exp_pc + 32'd8);
        chk("rnd_fields", {cond, op, funct, rd}, {16'd0, w[31:28], w[27:26], w[25:20], w[15:12]});
        if (!stall) begin
          consumed++;
          exp_pc = pcsrc ? (branch_target & ~32'h3) : exp_pc + 32'd4;
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      step;
    end
    chk("rnd_progress", {31'd0, consumed > 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
